e203_nts_ram_seq: RTL and testbench



---
 rtl/e203_nts_ram_seq.sv | 216 +++++++++++++++++++++
 tb/tb_e203_nts_ram_seq.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_nts_ram_seq.sv
// Nested-trap-save context RAM sequencer: moves 640-bit frames to/from a 128-bit
// single-port SRAM as five beats and shares the RAM with a one-beat debug read.
module e203_nts_ram_seq #(
    parameter int unsigned FRAME_W      = 640,
    parameter int unsigned BEAT_W       = 128,
    parameter int unsigned AW           = 8,
    parameter int unsigned DEPTH_FRAMES = 12,
    parameter int unsigned BASE_ADDR    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  save_req,
    input  logic [3:0]            save_idx,
    input  logic [FRAME_W-1:0]    save_data,
    output logic                  save_ack,
    input  logic                  rest_req,
    input  logic [3:0]            rest_idx,
    output logic [FRAME_W-1:0]    rest_data,
    output logic                  rest_vld,
    input  logic                  dbg_req,
    input  logic [AW-1:0]         dbg_addr,
    output logic [BEAT_W-1:0]     dbg_rdata,
    output logic                  dbg_ack,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [AW-1:0]         ram_addr,
    output logic [BEAT_W/8-1:0]   ram_wem,
    output logic [BEAT_W-1:0]     ram_din,
    input  logic [BEAT_W-1:0]     ram_dout,
    output logic                  busy,
    output logic                  err
);
    localparam int unsigned BEATS = FRAME_W / BEAT_W;
    localparam int unsigned WEM_W = BEAT_W / 8;
    localparam int unsigned CW    = 3;
    localparam int unsigned IW    = 4;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SAVE     = 3'd1;
    localparam logic [2:0] RD       = 3'd2;
    localparam logic [2:0] RD_TAIL  = 3'd3;
    localparam logic [2:0] DBG_RD   = 3'd4;
    localparam logic [2:0] DBG_TAIL = 3'd5;

    logic [2:0]                    state_q, state_d;
    logic [CW-1:0]                 beat_q, beat_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic [BEATS-1:0][BEAT_W-1:0]  frame_q, frame_d;
    logic [FRAME_W-1:0]            rest_q, rest_d;
    logic [BEAT_W-1:0]             dbg_q, dbg_d;
    logic                          cs_q, cs_d, we_q, we_d;
    logic [AW-1:0]                 addr_q, addr_d;
    logic [WEM_W-1:0]              wem_q, wem_d;
    logic [BEAT_W-1:0]             din_q, din_d;
    logic                          save_ack_q, save_ack_d, rest_vld_q, rest_vld_d;
    logic                          dbg_ack_q, dbg_ack_d, err_q, err_d, busy_q;
    logic                          rest_take, save_take, dbg_take;
    logic [FRAME_W-1:0]            tail_frame;

    function automatic logic [AW-1:0] slot_addr(input logic [IW-1:0] idx, input logic [CW-1:0] beat);
        return AW'(BASE_ADDR) + AW'(idx) * AW'(BEATS) + AW'(beat);
    endfunction

    // A requester still holds its req during its own ack cycle; don't re-accept it then.
    assign rest_take  = rest_req && !rest_vld_q;
    assign save_take  = save_req && !save_ack_q;
    assign dbg_take   = dbg_req  && !dbg_ack_q;
    assign tail_frame = {ram_dout, frame_q[BEATS-2:0]};

    // Next-state, datapath and next-output logic
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        idx_d      = idx_q;
        frame_d    = frame_q;
        rest_d     = rest_q;
        dbg_d      = dbg_q;
        cs_d       = 1'b0;
        we_d       = 1'b0;
        addr_d     = '0;
        wem_d      = '0;
        din_d      = '0;
        save_ack_d = 1'b0;
        rest_vld_d = 1'b0;
        dbg_ack_d  = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (rest_take) begin
                    idx_d = rest_idx;
                    if (32'(rest_idx) >= DEPTH_FRAMES) begin
                        rest_vld_d = 1'b1;
                        err_d      = 1'b1;
                        rest_d     = '0;
                    end else begin
                        state_d = RD;
                        cs_d    = 1'b1;
                        addr_d  = slot_addr(rest_idx, '0);
                    end
                end else if (save_take) begin
                    idx_d   = save_idx;
                    frame_d = save_data;
                    if (32'(save_idx) >= DEPTH_FRAMES) begin
                        save_ack_d = 1'b1;
                        err_d      = 1'b1;
                    end else begin
                        state_d = SAVE;
                        cs_d    = 1'b1;
                        we_d    = 1'b1;
                        wem_d   = '1;
                        addr_d  = slot_addr(save_idx, '0);
                        din_d   = save_data[BEAT_W-1:0];
                    end
                end else if (dbg_take) begin
                    state_d = DBG_RD;
                    cs_d    = 1'b1;
                    addr_d  = dbg_addr;
                end
            end
            SAVE: begin
                if (beat_q == CW'(BEATS - 1)) begin
                    state_d = IDLE;
                end else begin
                    beat_d     = beat_q + CW'(1);
                    cs_d       = 1'b1;
                    we_d       = 1'b1;
                    wem_d      = '1;
                    addr_d     = slot_addr(idx_q, beat_d);
                    din_d      = frame_q[beat_d];
                    save_ack_d = (beat_d == CW'(BEATS - 1));
                end
            end
            RD: begin
                // Data for the previous beat's read arrives this cycle
                if (beat_q != '0) begin
                    frame_d[beat_q - CW'(1)] = ram_dout;
                end
                if (beat_q == CW'(BEATS - 1)) begin
                    state_d    = RD_TAIL;
                    rest_vld_d = 1'b1;
                end else begin
                    beat_d = beat_q + CW'(1);
                    cs_d   = 1'b1;
                    addr_d = slot_addr(idx_q, beat_d);
                end
            end
            RD_TAIL: begin
                state_d = IDLE;
                rest_d  = tail_frame;
            end
            DBG_RD: begin
                state_d   = DBG_TAIL;
                dbg_ack_d = 1'b1;
            end
            DBG_TAIL: begin
                state_d = IDLE;
                dbg_d   = ram_dout;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            idx_q      <= '0;
            frame_q    <= '0;
            rest_q     <= '0;
            dbg_q      <= '0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wem_q      <= '0;
            din_q      <= '0;
            save_ack_q <= 1'b0;
            rest_vld_q <= 1'b0;
            dbg_ack_q  <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
            rest_q     <= rest_d;
            dbg_q      <= dbg_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wem_q      <= wem_d;
            din_q      <= din_d;
            save_ack_q <= save_ack_d;
            rest_vld_q <= rest_vld_d;
            dbg_ack_q  <= dbg_ack_d;
            err_q      <= err_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    // Last beat/debug word is presented straight from the RAM in the completion cycle
    assign rest_data = (state_q == RD_TAIL)  ? tail_frame : rest_q;
    assign dbg_rdata = (state_q == DBG_TAIL) ? ram_dout   : dbg_q;
    assign save_ack  = save_ack_q;
    assign rest_vld  = rest_vld_q;
    assign dbg_ack   = dbg_ack_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign ram_cs    = cs_q;
    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_wem   = wem_q;
    assign ram_din   = din_q;

endmodule

// File: tb/tb_e203_nts_ram_seq.sv
// Bench for e203_nts_ram_seq: behavioural SRAM plus a word-level memory model,
// scenario tasks with cycle-exact expectations derived from the frame timing rules.
module tb_e203_nts_ram_seq;
    localparam int unsigned FRAME_W = 640;
    localparam int unsigned BEAT_W  = 128;
    localparam int unsigned AW      = 8;
    localparam int unsigned BEATS   = 5;
    localparam int unsigned DEPTH   = 12;
    localparam int unsigned RW      = 2 + 16 + AW + BEAT_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               save_req = 1'b0, rest_req = 1'b0, dbg_req = 1'b0;
    logic [3:0]         save_idx = '0, rest_idx = '0;
    logic [FRAME_W-1:0] save_data = '0;
    logic [AW-1:0]      dbg_addr = '0;
    logic               save_ack, rest_vld, dbg_ack, busy, err;
    logic [FRAME_W-1:0] rest_data;
    logic [BEAT_W-1:0]  dbg_rdata, ram_din;
    logic               ram_cs, ram_we;
    logic [AW-1:0]      ram_addr;
    logic [15:0]        ram_wem;
    logic [BEAT_W-1:0]  ram_dout = '0;

    logic [BEAT_W-1:0]  ram [256] = '{default: '0};
    logic [BEAT_W-1:0]  mdl [256] = '{default: '0};
    int checks = 0;
    int errors = 0;

    e203_nts_ram_seq dut (
        .clk(clk), .rst_n(rst_n),
        .save_req(save_req), .save_idx(save_idx), .save_data(save_data), .save_ack(save_ack),
        .rest_req(rest_req), .rest_idx(rest_idx), .rest_data(rest_data), .rest_vld(rest_vld),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
        .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [BEAT_W-1:0] byte_mask(input logic [15:0] wem);
        logic [BEAT_W-1:0] m;
        for (int b = 0; b < 16; b++) m[8*b +: 8] = {8{wem[b]}};
        return m;
    endfunction

    // Single-port SRAM, one-cycle read latency
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) ram[ram_addr] <= (ram[ram_addr] & ~byte_mask(ram_wem)) | (ram_din & byte_mask(ram_wem));
            else        ram_dout <= ram[ram_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FRAME_W-1:0] rand_frame();
        logic [FRAME_W-1:0] f;
        for (int j = 0; j < FRAME_W / 32; j++) f[32*j +: 32] = $urandom;
        return f;
    endfunction

    function automatic logic [FRAME_W-1:0] count_frame();
        logic [FRAME_W-1:0] f;
        for (int j = 0; j < FRAME_W / 16; j++) f[16*j +: 16] = 16'(j);
        return f;
    endfunction

    function automatic logic [FRAME_W-1:0] model_frame(input logic [3:0] idx);
        logic [FRAME_W-1:0] f;
        f = '0;
        if (int'(idx) < DEPTH)
            for (int b = 0; b < BEATS; b++) f[BEAT_W*b +: BEAT_W] = mdl[int'(idx) * BEATS + b];
        return f;
    endfunction

    task automatic test_reset();
        step();
        step();
        checks++;
        if ({ram_cs, ram_we, ram_wem, ram_addr, ram_din, save_ack, rest_vld, dbg_ack, err, busy, dbg_rdata, rest_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs cs=%b we=%b busy=%b rest_data=%h dbg_rdata=%h required all 0", ram_cs, ram_we, busy, rest_data, dbg_rdata);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({ram_cs, ram_we, ram_wem, ram_addr, ram_din, save_ack, rest_vld, dbg_ack, err, busy} !== '0) begin
            errors++;
            $display("FAIL idle_after_reset cs=%b busy=%b err=%b required 0", ram_cs, busy, err);
        end
    endtask

    task automatic test_save(input logic [3:0] idx, input logic [FRAME_W-1:0] d);
        logic [RW-1:0] act, exp;
        save_idx = idx;
        save_data = d;
        save_req = 1'b1;
        if (int'(idx) >= DEPTH) begin
            for (int k = 1; k <= 3; k++) begin
                step();
                if (k == 2) save_req = 1'b0;
                checks++;
                if ({ram_cs, save_ack, err, busy} !== {1'b0, k == 1, k == 1, 1'b0}) begin
                    errors++;
                    $display("FAIL save_bad_idx idx=%0d k=%0d cs/ack/err/busy=%b required %b", idx, k,
                             {ram_cs, save_ack, err, busy}, {1'b0, k == 1, k == 1, 1'b0});
                end
            end
            return;
        end
        for (int k = 1; k <= BEATS + 1; k++) begin
            step();
            if (k == 1) save_data = ~d;
            if (k == BEATS + 1) save_req = 1'b0;
            exp = '0;
            if (k <= BEATS) exp = {1'b1, 1'b1, 16'hFFFF, AW'(int'(idx) * BEATS + k - 1), d[BEAT_W*(k-1) +: BEAT_W]};
            act = {ram_cs, ram_we, ram_wem, ram_addr, ram_din};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL save_ram idx=%0d k=%0d got %h required %h", idx, k, act, exp);
            end
            checks++;
            if ({save_ack, rest_vld, dbg_ack, err, busy} !== {k == BEATS, 1'b0, 1'b0, 1'b0, k <= BEATS}) begin
                errors++;
                $display("FAIL save_flags idx=%0d k=%0d ack/vld/dack/err/busy=%b required %b", idx, k,
                         {save_ack, rest_vld, dbg_ack, err, busy}, {k == BEATS, 1'b0, 1'b0, 1'b0, k <= BEATS});
            end
        end
        for (int b = 0; b < BEATS; b++) mdl[int'(idx) * BEATS + b] = d[BEAT_W*b +: BEAT_W];
    endtask

    task automatic test_restore(input logic [3:0] idx);
        logic [RW-1:0] act, exp;
        logic [FRAME_W-1:0] ef;
        ef = model_frame(idx);
        rest_idx = idx;
        rest_req = 1'b1;
        if (int'(idx) >= DEPTH) begin
            for (int k = 1; k <= 3; k++) begin
                step();
                if (k == 2) rest_req = 1'b0;
                checks++;
                if ({ram_cs, rest_vld, err, busy} !== {1'b0, k == 1, k == 1, 1'b0} || rest_data !== '0) begin
                    errors++;
                    $display("FAIL rest_bad_idx idx=%0d k=%0d cs/vld/err/busy=%b data=%h required %b and 0", idx, k,
                             {ram_cs, rest_vld, err, busy}, rest_data, {1'b0, k == 1, k == 1, 1'b0});
                end
            end
            return;
        end
        for (int k = 1; k <= BEATS + 2; k++) begin
            step();
            if (k == BEATS + 2) rest_req = 1'b0;
            exp = '0;
            if (k <= BEATS) exp = {1'b1, 1'b0, 16'h0, AW'(int'(idx) * BEATS + k - 1), BEAT_W'(0)};
            act = {ram_cs, ram_we, ram_wem, ram_addr, ram_din};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL rest_ram idx=%0d k=%0d got %h required %h", idx, k, act, exp);
            end
            checks++;
            if ({save_ack, rest_vld, dbg_ack, err, busy} !== {1'b0, k == BEATS + 1, 1'b0, 1'b0, k <= BEATS + 1}) begin
                errors++;
                $display("FAIL rest_flags idx=%0d k=%0d ack/vld/dack/err/busy=%b required %b", idx, k,
                         {save_ack, rest_vld, dbg_ack, err, busy}, {1'b0, k == BEATS + 1, 1'b0, 1'b0, k <= BEATS + 1});
            end
            if (k >= BEATS + 1) begin
                checks++;
                if (rest_data !== ef) begin
                    errors++;
                    $display("FAIL rest_data idx=%0d k=%0d got %h required %h", idx, k, rest_data, ef);
                end
            end
        end
    endtask

    task automatic test_dbg(input logic [AW-1:0] a);
        logic [RW-1:0] act, exp;
        dbg_addr = a;
        dbg_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k == 3) dbg_req = 1'b0;
            exp = (k == 1) ? {1'b1, 1'b0, 16'h0, a, BEAT_W'(0)} : '0;
            act = {ram_cs, ram_we, ram_wem, ram_addr, ram_din};
            checks++;
            if (act !== exp || {dbg_ack, busy} !== {k == 2, k <= 2}) begin
                errors++;
                $display("FAIL dbg_cycle addr=%h k=%0d ram=%h ack/busy=%b required %h %b", a, k, act, {dbg_ack, busy}, exp, {k == 2, k <= 2});
            end
            if (k == 2) begin
                checks++;
                if (dbg_rdata !== mdl[a]) begin
                    errors++;
                    $display("FAIL dbg_rdata addr=%h got %h required %h", a, dbg_rdata, mdl[a]);
                end
            end
        end
    endtask

    // Restore wins a same-cycle tie; the save follows as soon as the FSM is idle again
    task automatic test_collide();
        logic [RW-1:0] act, exp;
        logic [FRAME_W-1:0] d3, ef2;
        d3 = rand_frame();
        ef2 = model_frame(4'd2);
        save_idx = 4'd3; save_data = d3; rest_idx = 4'd2;
        save_req = 1'b1; rest_req = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 7) rest_req = 1'b0;
            if (k == 9) save_data = ~d3;
            if (k == 13) save_req = 1'b0;
            exp = '0;
            if (k <= 5) exp = {1'b1, 1'b0, 16'h0, AW'(10 + k - 1), BEAT_W'(0)};
            if (k >= 8 && k <= 12) exp = {1'b1, 1'b1, 16'hFFFF, AW'(15 + k - 8), d3[BEAT_W*(k-8) +: BEAT_W]};
            act = {ram_cs, ram_we, ram_wem, ram_addr, ram_din};
            checks++;
            if (act !== exp || {save_ack, rest_vld, busy} !== {k == 12, k == 6, (k <= 6) || (k >= 8 && k <= 12)}) begin
                errors++;
                $display("FAIL collide k=%0d ram=%h ack/vld/busy=%b required %h %b", k, act, {save_ack, rest_vld, busy},
                         exp, {k == 12, k == 6, (k <= 6) || (k >= 8 && k <= 12)});
            end
            if (k == 6) begin
                checks++;
                if (rest_data !== ef2) begin
                    errors++;
                    $display("FAIL collide_rest_data got %h required %h", rest_data, ef2);
                end
            end
        end
        for (int b = 0; b < BEATS; b++) mdl[15 + b] = d3[BEAT_W*b +: BEAT_W];
    endtask

    task automatic test_dbg_during_save();
        logic [RW-1:0] act, exp;
        logic [FRAME_W-1:0] d;
        d = rand_frame();
        save_idx = 4'd2; save_data = d; save_req = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 2) begin dbg_addr = 8'h0B; dbg_req = 1'b1; end
            if (k == 6) save_req = 1'b0;
            if (k == 9) dbg_req = 1'b0;
            exp = '0;
            if (k <= 5) exp = {1'b1, 1'b1, 16'hFFFF, AW'(10 + k - 1), d[BEAT_W*(k-1) +: BEAT_W]};
            if (k == 7) exp = {1'b1, 1'b0, 16'h0, 8'h0B, BEAT_W'(0)};
            act = {ram_cs, ram_we, ram_wem, ram_addr, ram_din};
            checks++;
            if (act !== exp || {save_ack, dbg_ack, busy} !== {k == 5, k == 8, (k <= 5) || k == 7 || k == 8}) begin
                errors++;
                $display("FAIL dbg_wait k=%0d ram=%h ack/dack/busy=%b required %h %b", k, act, {save_ack, dbg_ack, busy},
                         exp, {k == 5, k == 8, (k <= 5) || k == 7 || k == 8});
            end
            if (k == 8) begin
                checks++;
                if (dbg_rdata !== d[255:128]) begin
                    errors++;
                    $display("FAIL dbg_wait_rdata got %h required %h", dbg_rdata, d[255:128]);
                end
            end
        end
        for (int b = 0; b < BEATS; b++) mdl[10 + b] = d[BEAT_W*b +: BEAT_W];
    endtask

    task automatic test_reset_mid();
        logic [FRAME_W-1:0] d;
        d = rand_frame();
        save_idx = 4'd5; save_data = d; save_req = 1'b1;
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ram_cs, ram_we, ram_wem, ram_addr, ram_din, save_ack, rest_vld, dbg_ack, err, busy, dbg_rdata, rest_data} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs cs=%b we=%b addr=%h busy=%b rest_data=%h required all 0", ram_cs, ram_we, ram_addr, busy, rest_data);
        end
        save_req = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({ram_cs, busy, save_ack} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_idle cs/busy/ack=%b required 000", {ram_cs, busy, save_ack});
        end
        // Beats issued before reset landed in RAM; the rest of slot 5 is untouched
        mdl[25] = d[127:0];
        mdl[26] = d[255:128];
        test_dbg(8'd25);
        test_dbg(8'd27);
        test_save(4'd0, rand_frame());
    endtask

    task automatic test_back_to_back();
        test_save(4'd7, rand_frame());
        test_restore(4'd7);
        test_save(4'd11, rand_frame());
        test_save(4'd11, rand_frame());
        test_restore(4'd11);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0:       test_save(4'($urandom_range(0, 13)), rand_frame());
                1:       test_restore(4'($urandom_range(0, 13)));
                default: test_dbg(AW'($urandom_range(0, 63)));
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_save(4'd2, count_frame());
        test_restore(4'd2);
        test_collide();
        test_save(4'd12, rand_frame());
        test_restore(4'd15);
        test_dbg_during_save();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
